conv_job_scheduler: RTL and testbench
=====================================

Name: conv_job_scheduler

Overview:
- Shares one 3x3 convolution engine between two requesters, each submitting a 9-element kernel.
- Round-robin arbitration; pulses engine start, feeds the kernel over the kernel_valid/kernel_ready strobes, then consumes the 80-element output stream (8x10).
- Returns a per-job summary (sum, max, element count, engine cycle count, error flag) on a valid/ack response port.
- Sits between the board input logic (switches/UART kernel entry) and the convolution engine; the display reads its response.

Parameters:
- KERNEL_WIDTH, 4, width of one kernel element (0-9).
- ACC_WIDTH, 12, width of engine output element.
- SUM_WIDTH, 16, response sum width (80*729 = 58320 fits).
- TIMEOUT, 4096, watchdog limit in cycles for one job (START through RUN).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req  input  2  req[i]=1: requester i has a kernel pending (level, held until granted)
- req_kernel0  input  36  requester 0 kernel, element k at [4k+3:4k], k = row*3+col
- req_kernel1  input  36  requester 1 kernel, same packing
- grant  output  2  one-hot, one-cycle pulse when requester's kernel is captured
- eng_start  output  1  one-cycle start pulse to engine
- eng_kernel_in  output  KERNEL_WIDTH  kernel element to engine
- eng_kernel_valid  output  1  kernel element strobe
- eng_kernel_ready  input  1  engine waiting for kernel
- eng_out_valid  input  1  engine output element strobe
- eng_out_elem  input  ACC_WIDTH  engine output element
- eng_out_last  input  1  engine final element flag
- eng_cycle_count  input  16  engine compute cycle counter
- rsp_valid  output  1  job summary valid
- rsp_id  output  1  requester the summary belongs to
- rsp_sum  output  SUM_WIDTH  sum of all output elements
- rsp_max  output  ACC_WIDTH  maximum output element
- rsp_count  output  7  number of output elements received
- rsp_cycles  output  16  eng_cycle_count sampled at out_last (0 on timeout)
- rsp_error  output  1  timeout or count != 80
- rsp_ack  input  1  consumer accepts summary

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer = 0 (requester 0 favoured first); accumulators, idx, timer 0. Reset mid-job aborts the job silently; no response is produced.
- States: IDLE, START, LOAD, RUN, RESP.
- IDLE:
  - If any req, pick a winner: if both are set, the winner is the requester != last served (initially 0).
  - Capture the winner's kernel into an internal 36-bit register; pulse grant[winner]; clear sum/max/count/timer/idx; go to START.
  - Arbitration takes one cycle after req rises.
- START: eng_start=1 for exactly this cycle; go to LOAD.
- LOAD:
  - eng_kernel_valid = eng_kernel_ready (combinational, LOAD only); eng_kernel_in = kernel[idx] (combinational).
  - Transfer = valid & ready; idx increments per transfer.
  - On the 9th transfer (idx==8), go to RUN. Exactly 9 strobes per job, one per cycle maximum.
- RUN:
  - Each eng_out_valid: sum += elem (zero-extended), max = max(max, elem), count += 1.
  - On eng_out_valid & eng_out_last: latch rsp_cycles = eng_cycle_count; error = (count+1 != 80); go to RESP with the final element included.
- Watchdog:
  - Timer increments every cycle in START/LOAD/RUN.
  - Reaching TIMEOUT-1 forces RESP with rsp_error=1, rsp_cycles=0, and partial sum/max/count.
- RESP:
  - rsp_valid=1; rsp_* are stable while valid.
  - On rsp_ack: rsp_valid drops next cycle, last-served pointer = rsp_id, go to IDLE.
  - rsp_ack while not valid is ignored.
- Requests arriving while not IDLE wait; the current job is never preempted.
- Engine output strobes outside RUN are ignored.
- eng_out_valid and timeout in the same cycle: the element is counted, and out_last wins over timeout.
- Back-to-back jobs: minimum gap is one IDLE cycle after ack.

Test Plan:
- Reset then idle: all outputs 0, no grant for 20 cycles with req=0.
- req=01, kernel0 with k0=1, others 0, engine model attached:
  - grant=01 one cycle, eng_start one pulse, exactly 9 valid strobes in order 1,0,...,0.
  - rsp_valid with rsp_id=0, count=80, sum=360, max=9, error=0, rsp_cycles equal to the engine's final counter.
- req=11 simultaneously, kernel0 all zeros, kernel1 k0=2:
  - First grant=01: sum=0, max=0.
  - After ack, grant=10: sum=720, max=18.
  - Next simultaneous req grants 01 again (alternation).
- Engine stub emits 79 elements then out_last: rsp_error=1, rsp_count=79.
- Engine stub never asserts eng_kernel_ready, TIMEOUT=64: rsp_valid at cycle 64 after grant, rsp_error=1, count=0, rsp_cycles=0.
- rst_n asserted mid-RUN: outputs return to 0 immediately, no rsp_valid; a fresh req afterwards completes normally.

Source files
------------

// File: rtl/conv_job_scheduler_if.sv
// Scheduler-side bundle: requester kernels and grants, engine control/stream, job summary response.
// master = scheduler view; slave = environment (requesters, engine, display) view.
interface conv_job_scheduler_if #(
  parameter int KERNEL_WIDTH = 4,
  parameter int ACC_WIDTH    = 12,
  parameter int SUM_WIDTH    = 16
);
  logic [1:0]                  req;
  logic [9*KERNEL_WIDTH-1:0]   req_kernel0;
  logic [9*KERNEL_WIDTH-1:0]   req_kernel1;
  logic [1:0]                  grant;
  logic                        eng_start;
  logic [KERNEL_WIDTH-1:0]     eng_kernel_in;
  logic                        eng_kernel_valid;
  logic                        eng_kernel_ready;
  logic                        eng_out_valid;
  logic [ACC_WIDTH-1:0]        eng_out_elem;
  logic                        eng_out_last;
  logic [15:0]                 eng_cycle_count;
  logic                        rsp_valid;
  logic                        rsp_id;
  logic [SUM_WIDTH-1:0]        rsp_sum;
  logic [ACC_WIDTH-1:0]        rsp_max;
  logic [6:0]                  rsp_count;
  logic [15:0]                 rsp_cycles;
  logic                        rsp_error;
  logic                        rsp_ack;

  modport master (
    input  req, req_kernel0, req_kernel1,
    output grant,
    output eng_start, eng_kernel_in, eng_kernel_valid,
    input  eng_kernel_ready, eng_out_valid, eng_out_elem, eng_out_last, eng_cycle_count,
    output rsp_valid, rsp_id, rsp_sum, rsp_max, rsp_count, rsp_cycles, rsp_error,
    input  rsp_ack
  );

  modport slave (
    output req, req_kernel0, req_kernel1,
    input  grant,
    input  eng_start, eng_kernel_in, eng_kernel_valid,
    output eng_kernel_ready, eng_out_valid, eng_out_elem, eng_out_last, eng_cycle_count,
    input  rsp_valid, rsp_id, rsp_sum, rsp_max, rsp_count, rsp_cycles, rsp_error,
    output rsp_ack
  );
endinterface

// File: rtl/conv_job_scheduler.sv
// Round-robin sharing of one 3x3 conv engine between two requesters; one job summary per grant.
// Grant one cycle after req; kernel paced by eng_kernel_ready; response held until rsp_ack.
module conv_job_scheduler #(
  parameter int KERNEL_WIDTH = 4,
  parameter int ACC_WIDTH    = 12,
  parameter int SUM_WIDTH    = 16,
  parameter int TIMEOUT      = 4096
) (
  input logic                  clk,
  input logic                  rst_n,
  conv_job_scheduler_if.master bus
);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, START, LOAD, RUN, RESP} state_t;

  state_t                          state, state_nxt;
  logic   [8:0][KERNEL_WIDTH-1:0]  kernel_q;
  logic   [3:0]                    idx_q;
  logic   [TW-1:0]                 timer_q;
  logic   [SUM_WIDTH-1:0]          sum_q;
  logic   [ACC_WIDTH-1:0]          max_q;
  logic   [6:0]                    count_q;
  logic   [15:0]                   cycles_q;
  logic                            error_q;
  logic                            id_q;
  logic                            prio_q;
  logic   [1:0]                    grant_q;

  logic win;
  logic timeout;
  logic xfer;
  logic out_fire;
  logic [6:0] count_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt             = state;
    win                   = 1'b0;
    timeout               = (timer_q == TW'(TIMEOUT - 1));
    xfer                  = 1'b0;
    out_fire              = 1'b0;
    bus.eng_start         = 1'b0;
    bus.eng_kernel_valid  = 1'b0;
    bus.eng_kernel_in     = '0;
    bus.rsp_valid         = 1'b0;
    // prio_q names the requester favoured on a tie: the one not served last
    win = (bus.req == 2'b11) ? prio_q : bus.req[1];
    case (state)
      IDLE: begin
        if (|bus.req) state_nxt = START;
      end
      START: begin
        bus.eng_start = 1'b1;
        state_nxt     = timeout ? RESP : LOAD;
      end
      LOAD: begin
        xfer                 = bus.eng_kernel_ready;
        bus.eng_kernel_valid = xfer;
        bus.eng_kernel_in    = kernel_q[idx_q];
        if (timeout)                     state_nxt = RESP;
        else if (xfer && idx_q == 4'd8)  state_nxt = RUN;
      end
      RUN: begin
        out_fire = bus.eng_out_valid;
        if ((out_fire && bus.eng_out_last) || timeout) state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign count_inc = count_q + 7'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kernel_q <= '0;
      idx_q    <= '0;
      timer_q  <= '0;
      sum_q    <= '0;
      max_q    <= '0;
      count_q  <= '0;
      cycles_q <= '0;
      error_q  <= 1'b0;
      id_q     <= 1'b0;
      prio_q   <= 1'b0;
      grant_q  <= '0;
    end else begin
      grant_q <= '0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            kernel_q <= win ? bus.req_kernel1 : bus.req_kernel0;
            id_q     <= win;
            grant_q  <= win ? 2'b10 : 2'b01;
            idx_q    <= '0;
            timer_q  <= '0;
            sum_q    <= '0;
            max_q    <= '0;
            count_q  <= '0;
            cycles_q <= '0;
            error_q  <= 1'b0;
          end
        end
        START, LOAD, RUN: begin
          timer_q <= timer_q + 1'b1;
          if (xfer) idx_q <= idx_q + 4'd1;
          if (out_fire) begin
            sum_q   <= sum_q + SUM_WIDTH'(bus.eng_out_elem);
            count_q <= count_inc;
            if (bus.eng_out_elem > max_q) max_q <= bus.eng_out_elem;
          end
          // a final element beats a simultaneous watchdog expiry
          if (out_fire && bus.eng_out_last) begin
            cycles_q <= bus.eng_cycle_count;
            error_q  <= (count_inc != 7'd80);
          end else if (timeout) begin
            cycles_q <= '0;
            error_q  <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ack) prio_q <= ~id_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_sum    = sum_q;
  assign bus.rsp_max    = max_q;
  assign bus.rsp_count  = count_q;
  assign bus.rsp_cycles = cycles_q;
  assign bus.rsp_error  = error_q;
endmodule

// File: tb/tb_conv_job_scheduler.sv
// Directed bench for conv_job_scheduler with a behavioural conv engine on an image whose pixel = column % 10.
module tb_conv_job_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_job_scheduler_if #(.KERNEL_WIDTH(4), .ACC_WIDTH(12), .SUM_WIDTH(16)) bus ();
  conv_job_scheduler_if #(.KERNEL_WIDTH(4), .ACC_WIDTH(12), .SUM_WIDTH(16)) tbus ();

  conv_job_scheduler #(.KERNEL_WIDTH(4), .ACC_WIDTH(12), .SUM_WIDTH(16), .TIMEOUT(4096)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  conv_job_scheduler #(.KERNEL_WIDTH(4), .ACC_WIDTH(12), .SUM_WIDTH(16), .TIMEOUT(64)) u_to (
    .clk(clk), .rst_n(rst_n), .bus(tbus));

  int checks = 0;
  int errors = 0;
  int mode = 0;
  int strobes = 0;
  logic eng_busy;
  logic [3:0] ek [9];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] conv(input int e);
    int r, c, s;
    r = e / 10;
    c = e % 10;
    s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += int'(ek[i*3+j]) * ((c + j) % 10);
    return 12'(s + 0 * r);
  endfunction

  // Engine model: takes 9 kernel elements, then streams 80 (or 79 in mode 1) results.
  initial begin
    int kc;
    int n;
    bus.eng_kernel_ready = 1'b0;
    bus.eng_out_valid    = 1'b0;
    bus.eng_out_elem     = '0;
    bus.eng_out_last     = 1'b0;
    bus.eng_cycle_count  = '0;
    eng_busy             = 1'b0;
    for (int k = 0; k < 9; k++) ek[k] = '0;
    forever begin
      @(negedge clk);
      if (bus.eng_start) begin
        eng_busy = 1'b1;
        bus.eng_kernel_ready = 1'b1;
        kc = 0;
        for (int g = 0; g < 50 && kc < 9; g++) begin
          @(negedge clk);
          if (bus.eng_kernel_valid) begin
            ek[kc] = bus.eng_kernel_in;
            kc++;
          end
        end
        @(negedge clk);
        bus.eng_kernel_ready = 1'b0;
        n = (mode == 1) ? 79 : 80;
        for (int e = 0; e < n; e++) begin
          bus.eng_out_valid   = 1'b1;
          bus.eng_out_elem    = conv(e);
          bus.eng_out_last    = (e == n - 1);
          bus.eng_cycle_count = 16'(1000 + e);
          @(negedge clk);
        end
        bus.eng_out_valid = 1'b0;
        bus.eng_out_last  = 1'b0;
        eng_busy = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.eng_kernel_valid) strobes++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "bench timeout");
  end

  task automatic get_grant(input logic [1:0] exp);
    int n = 0;
    while (bus.grant == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("grant", bus.grant, exp);
    chk("start_with_grant", bus.eng_start, 1);
    bus.req = bus.req & ~bus.grant;
    @(negedge clk);
    chk("grant_pulse", {bus.grant, bus.eng_start}, 0);
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!bus.rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_valid", bus.rsp_valid, 1);
  endtask

  task automatic check_rsp(input logic id, input int sum, input int mx, input int cnt,
                           input logic err, input int cyc);
    chk("rsp_id", bus.rsp_id, id);
    chk("rsp_sum", bus.rsp_sum, sum);
    chk("rsp_max", bus.rsp_max, mx);
    chk("rsp_count", bus.rsp_count, cnt);
    chk("rsp_error", bus.rsp_error, err);
    chk("rsp_cycles", bus.rsp_cycles, cyc);
  endtask

  task automatic do_ack();
    bus.rsp_ack = 1'b1;
    @(negedge clk);
    bus.rsp_ack = 1'b0;
    chk("rsp_drop", bus.rsp_valid, 0);
  endtask

  initial begin
    int bad;
    int n;
    int s0;
    bus.req = 2'b00;
    bus.req_kernel0 = '0;
    bus.req_kernel1 = '0;
    bus.rsp_ack = 1'b0;
    tbus.req = 2'b00;
    tbus.req_kernel0 = '0;
    tbus.req_kernel1 = '0;
    tbus.rsp_ack = 1'b0;
    tbus.eng_kernel_ready = 1'b0;
    tbus.eng_out_valid = 1'b0;
    tbus.eng_out_elem = '0;
    tbus.eng_out_last = 1'b0;
    tbus.eng_cycle_count = '0;

    repeat (3) @(negedge clk);
    chk("rst_ctrl", {bus.grant, bus.eng_start, bus.eng_kernel_in, bus.eng_kernel_valid,
                     bus.rsp_valid, bus.rsp_id, bus.rsp_error}, 0);
    chk("rst_data", {bus.rsp_sum, bus.rsp_max, bus.rsp_count, bus.rsp_cycles}, 0);
    rst_n = 1'b1;

    // Quiet idle, including a stray ack that must be ignored
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      bus.rsp_ack = (i == 5);
      @(negedge clk);
      if (bus.grant != 2'b00 || bus.eng_start || bus.rsp_valid || bus.eng_kernel_valid) bad++;
    end
    bus.rsp_ack = 1'b0;
    chk("idle_quiet", bad, 0);

    // Simultaneous requests: 0 first, then 1, then 0 again
    bus.req_kernel0 = 36'h0;
    bus.req_kernel1 = 36'h2;
    bus.req = 2'b11;
    get_grant(2'b01);
    wait_rsp();
    check_rsp(1'b0, 0, 0, 80, 1'b0, 1079);
    do_ack();
    get_grant(2'b10);
    wait_rsp();
    check_rsp(1'b1, 720, 18, 80, 1'b0, 1079);
    do_ack();
    bus.req = 2'b11;
    get_grant(2'b01);
    bus.req = 2'b00;
    wait_rsp();
    chk("alt_rsp_id", bus.rsp_id, 0);
    do_ack();

    // Single requester, k0=1: identity-like kernel on the column ramp
    bus.req_kernel0 = 36'h1;
    s0 = strobes;
    bus.req = 2'b01;
    get_grant(2'b01);
    wait_rsp();
    chk("kernel_strobes", strobes - s0, 9);
    chk("kernel_first", ek[0], 1);
    chk("kernel_rest", {ek[1], ek[2], ek[3], ek[4], ek[5], ek[6], ek[7], ek[8]}, 0);
    check_rsp(1'b0, 360, 9, 80, 1'b0, 1079);
    @(negedge clk);
    chk("rsp_hold", {bus.rsp_valid, bus.rsp_sum}, {1'b1, 16'd360});
    do_ack();

    // Short stream: 79 elements then last
    mode = 1;
    bus.req = 2'b01;
    get_grant(2'b01);
    wait_rsp();
    chk("short_count", bus.rsp_count, 79);
    chk("short_error", bus.rsp_error, 1);
    chk("short_cycles", bus.rsp_cycles, 1078);
    do_ack();
    mode = 0;

    // Watchdog on the TIMEOUT=64 instance with no kernel_ready
    tbus.req = 2'b01;
    n = 0;
    while (tbus.grant == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("to_grant", tbus.grant, 2'b01);
    tbus.req = 2'b00;
    n = 0;
    while (!tbus.rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("to_latency", n, 64);
    chk("to_error", tbus.rsp_error, 1);
    chk("to_count", tbus.rsp_count, 0);
    chk("to_cycles", tbus.rsp_cycles, 0);
    chk("to_strobes", tbus.eng_kernel_valid, 0);
    tbus.rsp_ack = 1'b1;
    @(negedge clk);
    tbus.rsp_ack = 1'b0;
    chk("to_drop", tbus.rsp_valid, 0);

    // Reset in the middle of RUN
    bus.req_kernel0 = 36'h1;
    bus.req = 2'b01;
    get_grant(2'b01);
    repeat (30) @(negedge clk);
    chk("mid_run_count_nonzero", bus.rsp_count != 7'd0, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst", {bus.grant, bus.eng_start, bus.eng_kernel_valid, bus.rsp_valid,
                      bus.rsp_count, bus.rsp_sum}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    n = 0;
    while (eng_busy && n < 200) begin
      @(negedge clk);
      if (bus.rsp_valid) bad++;
      n++;
    end
    chk("no_rsp_after_rst", bad, 0);
    chk("engine_drained", eng_busy, 0);
    bus.req = 2'b01;
    get_grant(2'b01);
    wait_rsp();
    check_rsp(1'b0, 360, 9, 80, 1'b0, 1079);
    do_ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
